// File: rtl/rxfsmslow_push.sv
// Receiver half of the slow 4-phase push synchronizer: syncs req, captures datai once per req phase.
// Optional macro RXSLOW_SYNC3_EN adds a third synchronizer flop in front of the FSM.
module rxfsmslow_push #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [DW-1:0] datai,
  output logic          ack,
  output logic          rxe,
  output logic          valo,
  output logic [DW-1:0] datao,
  input  logic          rdy
);

`ifdef RXSLOW_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  localparam logic [1:0] ST_RST  = 2'b00;
  localparam logic [1:0] ST_IDLE = 2'b01;
  localparam logic [1:0] ST_ACK  = 2'b10;

  logic [SYNC_N-1:0] sync_reg;
  logic [SYNC_N-1:0] sync_next;
  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic              valo_reg;
  logic              valo_next;
  logic [DW-1:0]     datao_reg;
  logic [DW-1:0]     datao_next;
  logic              req_s;
  logic              buf_free;
  logic              capture;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_N; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = req;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  // Only the last synchronizer stage is safe to use in this domain.
  assign req_s    = sync_reg[SYNC_N-1];
  assign buf_free = ~valo_reg | rdy;
  assign capture  = (state_reg == ST_IDLE) & req_s & buf_free;

  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_RST:  state_next = ST_IDLE;
      ST_IDLE: state_next = capture ? ST_ACK : ST_IDLE;
      ST_ACK:  state_next = req_s ? ST_ACK : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // A capture wins over a drain in the same cycle so the new word stays valid.
  always_comb begin
    valo_next  = valo_reg;
    datao_next = datao_reg;
    if (valo_reg && rdy) begin
      valo_next = 1'b0;
    end
    if (capture) begin
      valo_next  = 1'b1;
      datao_next = datai;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg  <= '0;
      state_reg <= ST_RST;
      valo_reg  <= 1'b0;
      datao_reg <= '0;
    end else begin
      sync_reg  <= sync_next;
      state_reg <= state_next;
      valo_reg  <= valo_next;
      datao_reg <= datao_next;
    end
  end

  assign ack   = (state_reg == ST_ACK);
  assign rxe   = (state_reg == ST_IDLE) || (state_reg == ST_ACK);
  assign valo  = valo_reg;
  assign datao = datao_reg;

endmodule

// File: tb/tb_rxfsmslow_push.sv
// Self-checking bench for rxfsmslow_push: vector table, corner sequences, random run vs phase model.
module tb_rxfsmslow_push;

`ifdef RXSLOW_SYNC3_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic [7:0] datai = 8'h00;
  logic       rdy = 1'b0;
  logic       ack;
  logic       rxe;
  logic       valo;
  logic [7:0] datao;

  int n_checks = 0;
  int n_fail   = 0;

  rxfsmslow_push #(.DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .datai (datai),
    .ack   (ack),
    .rxe   (rxe),
    .valo  (valo),
    .datao (datao),
    .rdy   (rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       rq;
    logic       rd;
    logic [7:0] din;
    logic       e_ack;
    logic       e_valo;
    logic       e_rxe;
    logic [7:0] e_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic rq, input logic rd, input logic [7:0] din,
                              input logic e_ack, input logic e_valo, input logic e_rxe,
                              input logic [7:0] e_dout);
    vec_t v;
    v.rst = rst; v.rq = rq; v.rd = rd; v.din = din;
    v.e_ack = e_ack; v.e_valo = e_valo; v.e_rxe = e_rxe; v.e_dout = e_dout;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input int lim, input string nm);
    int n = 0;
    while (ack !== lvl && n < lim) begin
      tick();
      n++;
    end
    check(nm, {7'd0, ack}, {7'd0, lvl});
  endtask

  // Reference model: delayed view of req, "this phase already served" flag, one-word buffer.
  bit         m_q[$];
  bit         m_en, m_served, m_valid;
  logic [7:0] m_data;

  function automatic void model_step(input logic rst, input logic rq, input logic rd, input logic [7:0] din);
    bit d, cap;
    if (rst) begin
      m_q = {};
      for (int i = 0; i < LAT; i++) m_q.push_back(1'b0);
      m_en = 0; m_served = 0; m_valid = 0; m_data = 8'h00;
    end else begin
      d   = m_q[0];
      cap = m_en && d && !m_served && (!m_valid || rd);
      if (m_valid && rd) m_valid = 0;
      if (cap) begin
        m_valid  = 1;
        m_data   = din;
        m_served = 1;
      end
      if (!d) m_served = 0;
      m_en = 1;
      void'(m_q.pop_front());
      m_q.push_back(rq);
    end
  endfunction

  initial begin
    int pulses, vcycles;
    logic prev_v;

    // Reset and idle
    for (int i = 0; i < 3; i++) add(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 8'h00, 0, 0, 1, 8'h00);
    // Single transfer with rdy=1
    add(0, 1, 1, 8'hA5, 0, 0, 1, 8'h00);
    for (int i = 1; i < LAT; i++) add(0, 1, 1, 8'hA5, 0, 0, 1, 8'h00);
    add(0, 1, 1, 8'hA5, 1, 1, 1, 8'hA5);
    add(0, 0, 1, 8'hA5, 1, 0, 1, 8'hA5);
    for (int i = 1; i < LAT; i++) add(0, 0, 1, 8'hA5, 1, 0, 1, 8'hA5);
    add(0, 0, 1, 8'hA5, 0, 0, 1, 8'hA5);
    add(0, 0, 1, 8'hA5, 0, 0, 1, 8'hA5);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; req = vecs[i].rq; rdy = vecs[i].rd; datai = vecs[i].din;
      tick();
      $display("vec %0d: rst=%b req=%b rdy=%b -> ack=%b valo=%b rxe=%b datao=%h",
               i, reset, req, rdy, ack, valo, rxe, datao);
      check($sformatf("vec%0d.ack", i), {7'd0, ack}, {7'd0, vecs[i].e_ack});
      check($sformatf("vec%0d.valo", i), {7'd0, valo}, {7'd0, vecs[i].e_valo});
      check($sformatf("vec%0d.rxe", i), {7'd0, rxe}, {7'd0, vecs[i].e_rxe});
      check($sformatf("vec%0d.datao", i), datao, vecs[i].e_dout);
    end

    // Backpressure: first word parked, second req must wait
    rdy = 0; datai = 8'h11; req = 1;
    wait_ack(1, 20, "bp1_ack_rise");
    req = 0;
    wait_ack(0, 20, "bp1_ack_fall");
    check("bp1_valo", {7'd0, valo}, 8'd1);
    check("bp1_datao", datao, 8'h11);
    datai = 8'h22; req = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp2_hold_ack", {7'd0, ack}, 8'd0);
      check("bp2_hold_datao", datao, 8'h11);
    end
    rdy = 1;
    tick();
    check("bp2_swap_datao", datao, 8'h22);
    check("bp2_swap_valo", {7'd0, valo}, 8'd1);
    check("bp2_swap_ack", {7'd0, ack}, 8'd1);
    tick();
    check("bp2_drained", {7'd0, valo}, 8'd0);
    req = 0;
    wait_ack(0, 20, "bp2_ack_fall");
    $display("backpressure sequence done, datao=%h", datao);

    // Long req phase: one capture only
    rdy = 1; datai = 8'h3C; req = 1;
    pulses = 0; vcycles = 0; prev_v = valo;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valo) vcycles++;
      if (valo && !prev_v) pulses++;
      prev_v = valo;
    end
    check("hold_pulses", pulses[7:0], 8'd1);
    check("hold_vcycles", vcycles[7:0], 8'd1);
    check("hold_datao", datao, 8'h3C);
    check("hold_ack_up", {7'd0, ack}, 8'd1);
    req = 0;
    for (int i = 0; i < LAT; i++) begin
      tick();
      check("hold_ack_tail", {7'd0, ack}, 8'd1);
    end
    tick();
    check("hold_ack_off", {7'd0, ack}, 8'd0);
    $display("long req sequence done, pulses=%0d", pulses);

    // Reset while in ACK with a parked word
    rdy = 0; datai = 8'h77; req = 1;
    wait_ack(1, 20, "rst_pre_ack");
    check("rst_pre_valo", {7'd0, valo}, 8'd1);
    reset = 1;
    tick();
    check("rst_ack", {7'd0, ack}, 8'd0);
    check("rst_valo", {7'd0, valo}, 8'd0);
    check("rst_rxe", {7'd0, rxe}, 8'd0);
    check("rst_datao", datao, 8'h00);
    reset = 0; datai = 8'h5C;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      check($sformatf("rel_edge%0d_valo", i), {7'd0, valo}, 8'd0);
    end
    tick();
    check("rel_cap_valo", {7'd0, valo}, 8'd1);
    check("rel_cap_datao", datao, 8'h5C);
    check("rel_cap_ack", {7'd0, ack}, 8'd1);
    req = 0; rdy = 1;
    wait_ack(0, 20, "rel_ack_fall");
    $display("reset-in-ack sequence done");

    // Randomized run against the model
    reset = 1; req = 0; rdy = 0; datai = 8'h00;
    for (int i = 0; i < 2; i++) begin
      model_step(reset, req, rdy, datai);
      tick();
    end
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 3) == 0) req = ~req;
      rdy   = $urandom_range(0, 1);
      datai = 8'($urandom);
      model_step(reset, req, rdy, datai);
      tick();
      if (valo && rdy && !reset) $display("rand cyc %0d: word %h delivered", c, datao);
      check("rand_ack", {7'd0, ack}, {7'd0, m_served});
      check("rand_valo", {7'd0, valo}, {7'd0, m_valid});
      check("rand_rxe", {7'd0, rxe}, {7'd0, m_en});
      check("rand_datao", datao, m_data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
